// File: rtl/my_pipelined_leftshifter_pkg.sv
// Shared defaults and shift-split constants for the pipelined left shifter.
package my_pipelined_leftshifter_pkg;

  // Default operand, shift-amount and tag widths.
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SHAMT_W = 5;
  localparam int DEF_TAG_W   = 5;

  // Number of low shift-amount bits resolved in the second stage (steps 4, 2, 1).
  localparam int LO_SHAMT_BITS = 3;

  // Shift distance controlled by shift-amount bit number bit_idx.
  function automatic int step_size(input int bit_idx);
    return 1 << bit_idx;
  endfunction

endpackage

// File: rtl/my_pipelined_leftshifter_stage.sv
// One power-of-two step of the left barrel shifter: shift by SHIFT or pass through.
module my_leftshift_stage
  import my_pipelined_leftshifter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHIFT = 1
) (
  input  logic [WIDTH-1:0] data_input,
  input  logic             control_bit,
  output logic [WIDTH-1:0] data_output
);

  // Vacated low bits are zero-filled; bits shifted past the MSB are dropped.
  assign data_output = control_bit ? {data_input[WIDTH-1-SHIFT:0], {SHIFT{1'b0}}}
                                   : data_input;

endmodule

// File: rtl/my_pipelined_leftshifter.sv
// Two-stage pipelined logical left shifter with valid/ready handshakes,
// flush and a sideband tag. Stage 1 resolves the large steps (16, 8), stage 2
// the small steps (4, 2, 1).
module my_pipelined_leftshifter
  import my_pipelined_leftshifter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W,
  parameter int TAG_W   = DEF_TAG_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int HI_BITS = SHAMT_W - LO_SHAMT_BITS;

  // Stage registers.
  logic                     r_s1_valid;
  logic [WIDTH-1:0]         r_s1_data;
  logic [LO_SHAMT_BITS-1:0] r_s1_shamt;
  logic [TAG_W-1:0]         r_s1_tag;
  logic                     r_s2_valid;
  logic [WIDTH-1:0]         r_out_data;
  logic [TAG_W-1:0]         r_out_tag;

  // Handshake and datapath wires.
  logic                              w_s1_ready;
  logic                              w_s2_ready;
  logic                              w_in_fire;
  logic                              w_advance;
  logic [HI_BITS:0][WIDTH-1:0]       w_s1_chain;
  logic [LO_SHAMT_BITS:0][WIDTH-1:0] w_s2_chain;

  // Ready flows backwards combinationally so a full pipeline still moves every cycle.
  assign w_s2_ready = !r_s2_valid | out_ready;
  assign w_s1_ready = !r_s1_valid | w_s2_ready;
  assign in_ready   = w_s1_ready & !flush;
  assign w_in_fire  = in_valid & in_ready;
  assign w_advance  = r_s1_valid & w_s2_ready & !flush;

  // Large steps, MSB of the shift amount first, feeding the stage-1 register.
  assign w_s1_chain[0] = in_data;
  generate
    for (genvar gi = 0; gi < HI_BITS; gi++) begin : g_s1_step
      my_leftshift_stage #(
        .WIDTH(WIDTH),
        .SHIFT(step_size(SHAMT_W - 1 - gi))
      ) u_step (
        .data_input (w_s1_chain[gi]),
        .control_bit(in_shamt[SHAMT_W-1-gi]),
        .data_output(w_s1_chain[gi+1])
      );
    end
  endgenerate

  // Small steps driven by the registered low shift-amount bits.
  assign w_s2_chain[0] = r_s1_data;
  generate
    for (genvar gi = 0; gi < LO_SHAMT_BITS; gi++) begin : g_s2_step
      my_leftshift_stage #(
        .WIDTH(WIDTH),
        .SHIFT(step_size(LO_SHAMT_BITS - 1 - gi))
      ) u_step (
        .data_input (w_s2_chain[gi]),
        .control_bit(r_s1_shamt[LO_SHAMT_BITS-1-gi]),
        .data_output(w_s2_chain[gi+1])
      );
    end
  endgenerate

  // Valid bits: flush empties both stages and wins over every other event.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_in_fire | (r_s1_valid & !w_s2_ready);
      r_s2_valid <= (r_s1_valid & w_s2_ready) | (r_s2_valid & !out_ready);
    end
  end

  // Stage data loads only on a transfer, so stalled contents hold stable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_data  <= '0;
      r_s1_shamt <= '0;
      r_s1_tag   <= '0;
      r_out_data <= '0;
      r_out_tag  <= '0;
    end else begin
      if (w_in_fire) begin
        r_s1_data  <= w_s1_chain[HI_BITS];
        r_s1_shamt <= in_shamt[LO_SHAMT_BITS-1:0];
        r_s1_tag   <= in_tag;
      end
      if (w_advance) begin
        r_out_data <= w_s2_chain[LO_SHAMT_BITS];
        r_out_tag  <= r_s1_tag;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_my_pipelined_leftshifter.sv
// Self-checking bench for my_pipelined_leftshifter: vector table, hand-written
// handshake/flush/reset sequences and a randomized run against a shift model.
module tb_my_pipelined_leftshifter;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
  } exp_t;

  vec_t vecs[8];
  exp_t q[$];

  my_pipelined_leftshifter #(.WIDTH(32), .SHAMT_W(5), .TAG_W(5)) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag)
  );

  always #5 clock = ~clock;

  // Reference: a logical left shift of a 32-bit value, excess bits discarded.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s);
    logic [63:0] wide;
    wide = {32'd0, d} * (64'd1 << s);
    return wide[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic [4:0] s, input logic [4:0] t);
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s;
    in_tag   = t;
  endtask

  // Scoreboard monitor: records accepted operands and checks every delivered result.
  initial begin
    exp_t        e;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic [4:0]  prev_tag;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_tag   = '0;
    forever begin
      @(negedge clock);
      if (reset || flush) begin
        q.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && out_valid) begin
          check("stall_hold_data", out_data, prev_data);
          check("stall_hold_tag", {27'd0, out_tag}, {27'd0, prev_tag});
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got tag %0d data %h with nothing expected", out_tag, out_data);
          end else begin
            e = q.pop_front();
            check("sb_data", out_data, e.data);
            check("sb_tag", {27'd0, out_tag}, {27'd0, e.tag});
          end
        end
        if (in_valid && in_ready) begin
          e.data = ref_shift(in_data, in_shamt);
          e.tag  = in_tag;
          q.push_back(e);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_tag   = out_tag;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       seen_valid[8];
    logic [4:0] seen_tag[8];

    vecs[0] = '{32'h0000_0001, 5'd31, 5'd1,  32'h8000_0000};
    vecs[1] = '{32'hFFFF_FFFF, 5'd16, 5'd2,  32'hFFFF_0000};
    vecs[2] = '{32'h1234_5678, 5'd0,  5'd3,  32'h1234_5678};
    vecs[3] = '{32'h1234_5678, 5'd4,  5'd4,  32'h2345_6780};
    vecs[4] = '{32'hA5A5_A5A5, 5'd1,  5'd5,  32'h4B4B_4B4A};
    vecs[5] = '{32'h8000_0001, 5'd31, 5'd6,  32'h8000_0000};
    vecs[6] = '{32'hDEAD_BEEF, 5'd8,  5'd7,  32'hADBE_EF00};
    vecs[7] = '{32'h0000_FFFF, 5'd20, 5'd31, 32'hFFF0_0000};

    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    #2;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_out_tag", {27'd0, out_tag}, 32'd0);
    @(negedge clock);
    #2 reset = 1'b0;
    tick();
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Vector table: each result appears two edges after acceptance.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].data, vecs[i].shamt, vecs[i].tag);
      #1 check("vec_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      #1 check("vec_latency_not_early", {31'd0, out_valid}, 32'd0);
      tick();
      #1;
      check("vec_out_valid", {31'd0, out_valid}, 32'd1);
      check("vec_out_data", out_data, vecs[i].exp);
      check("vec_out_tag", {27'd0, out_tag}, {27'd0, vecs[i].tag});
      $display("vector %0d: data=%h shamt=%0d -> out=%h tag=%0d", i, vecs[i].data, vecs[i].shamt, out_data, out_tag);
    end
    tick();
    tick();

    // Throughput: four back-to-back operands, tags 1..4 on consecutive cycles.
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k < 4) drive(32'h0000_0001 << k, 5'(k), 5'(k + 1));
      else       in_valid = 1'b0;
      #1;
      if (k < 4) check("tput_in_ready", {31'd0, in_ready}, 32'd1);
      seen_valid[k] = out_valid;
      seen_tag[k]   = out_tag;
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("tput_out_valid", {31'd0, seen_valid[k]}, (k >= 2 && k <= 5) ? 32'd1 : 32'd0);
      if (k >= 2 && k <= 5) check("tput_out_tag", {27'd0, seen_tag[k]}, 32'(k - 1));
    end
    $display("throughput: tags delivered on cycles 2..5");

    // Backpressure: third operand is refused until the consumer is ready.
    out_ready = 1'b0;
    drive(32'h0000_0001, 5'd3, 5'd5);
    #1 check("bp_accept_a", {31'd0, in_ready}, 32'd1);
    tick();
    drive(32'h0000_0002, 5'd3, 5'd6);
    #1 check("bp_accept_b", {31'd0, in_ready}, 32'd1);
    tick();
    drive(32'h0000_0003, 5'd3, 5'd7);
    #1;
    check("bp_refuse_c", {31'd0, in_ready}, 32'd0);
    check("bp_out_tag_a", {27'd0, out_tag}, 32'd5);
    tick();
    #1 check("bp_still_refused", {31'd0, in_ready}, 32'd0);
    tick();
    #1;
    check("bp_hold_data", out_data, 32'h0000_0008);
    check("bp_hold_tag", {27'd0, out_tag}, 32'd5);
    out_ready = 1'b1;
    #1 check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    #1 check("bp_drain_b", {27'd0, out_tag}, 32'd6);
    tick();
    #1 check("bp_drain_c", {27'd0, out_tag}, 32'd7);
    tick();
    #1 check("bp_drained", {31'd0, out_valid}, 32'd0);
    $display("backpressure: drained tags 5,6,7 in order");

    // Flush with both stages full and an operand offered.
    out_ready = 1'b0;
    drive(32'h0000_0011, 5'd1, 5'd8);
    tick();
    drive(32'h0000_0022, 5'd1, 5'd9);
    tick();
    drive(32'h0000_0033, 5'd1, 5'd10);
    flush = 1'b1;
    #1;
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    check("flush_pre_valid", {31'd0, out_valid}, 32'd1);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1 check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    #1 check("flush_s1_killed", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    drive(32'h0000_00FF, 5'd24, 5'd11);
    tick();
    in_valid = 1'b0;
    tick();
    #1;
    check("post_flush_valid", {31'd0, out_valid}, 32'd1);
    check("post_flush_data", out_data, 32'hFF00_0000);
    check("post_flush_tag", {27'd0, out_tag}, 32'd11);
    $display("flush: post-flush result tag=%0d data=%h", out_tag, out_data);
    tick();

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    drive(32'h0000_0005, 5'd2, 5'd12);
    tick();
    drive(32'h0000_0006, 5'd2, 5'd13);
    tick();
    in_valid = 1'b0;
    #1 check("rst_pre_valid", {31'd0, out_valid}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_async_valid", {31'd0, out_valid}, 32'd0);
    check("rst_async_data", out_data, 32'd0);
    check("rst_async_tag", {27'd0, out_tag}, 32'd0);
    @(negedge clock);
    #2 reset = 1'b0;
    tick();
    out_ready = 1'b1;
    drive(32'h0000_0003, 5'd30, 5'd14);
    tick();
    in_valid = 1'b0;
    #1 check("rst_resume_not_early", {31'd0, out_valid}, 32'd0);
    tick();
    #1;
    check("rst_resume_valid", {31'd0, out_valid}, 32'd1);
    check("rst_resume_data", out_data, 32'hC000_0000);
    check("rst_resume_tag", {27'd0, out_tag}, 32'd14);
    $display("reset: resumed with tag=%0d data=%h", out_tag, out_data);
    tick();

    // Random traffic with stalls and occasional flushes, checked by the scoreboard.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = $urandom();
      in_shamt  = 5'($urandom_range(0, 31));
      in_tag    = 5'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 49) == 0);
      tick();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (out_valid || q.size() != 0); c++) tick();
    #1;
    check("random_drain_queue", q.size(), 32'd0);
    check("random_drain_valid", {31'd0, out_valid}, 32'd0);
    $display("random: 400 cycles complete");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
